attr_fetch_ctrl: RTL and testbench
==================================

ATTR_FETCH_CTRL -- requirements
Module: attr_fetch_ctrl

Interface
REQ-001 SHALL have parameter NT_BASE, default 14'h2000, PPU address of physical nametable 0.
REQ-002 SHALL have parameter NT_SIZE, default 14'h0400, byte stride between physical nametables.
REQ-003 SHALL have parameter TILE_COLS, default 32, tiles per nametable row.
REQ-004 SHALL have parameter TILE_ROWS, default 30, tile rows per nametable; attribute area starts at offset TILE_COLS*TILE_ROWS.
REQ-005 SHALL have ports, one per line:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  lookup request
- req_ready  out  1  block can accept
- req_addr  in  14  PPU nametable address (0x2000-0x3EFF)
- mirror_mode  in  2  00 horizontal, 01 vertical, 10 single-A, 11 single-B
- cache_inval  in  1  clear cached attribute byte
- mem_req  out  1  attribute read request
- mem_gnt  in  1  request accepted
- mem_addr  out  14  attribute byte address
- mem_rd_valid  in  1  read data strobe
- mem_rd_data  in  8  attribute byte
- pal_valid  out  1  result valid
- pal_ready  in  1  consumer accepts
- pal_sel  out  2  palette select
- pal_err  out  1  request addressed attribute area

Function
REQ-006 SHALL decode: logical table = req_addr[11:10]; offset = req_addr[9:0]; row = offset/TILE_COLS; col = offset%TILE_COLS.
REQ-007 SHALL map physical table: horizontal -> logical[1]; vertical -> logical[0]; single-A -> 0; single-B -> 1.
REQ-008 SHALL compute mem_addr = NT_BASE + phys*NT_SIZE + TILE_COLS*TILE_ROWS + (row>>2)*(TILE_COLS/4) + (col>>2), 14-bit wrap.
REQ-009 SHALL select pal_sel = attribute byte bits [shift+1:shift], shift = {row[1], col[1], 1'b0}.
REQ-010 SHALL sample req_addr and mirror_mode only on the accept cycle (req_valid & req_ready).
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, OUT; req_ready = (state==IDLE).
REQ-012 IDLE -> ISSUE on accept; ISSUE holds mem_req=1 and stable mem_addr until mem_gnt, then WAIT; WAIT -> OUT on mem_rd_valid, registering pal_sel; OUT holds pal_valid and outputs stable until pal_ready, then IDLE.
REQ-013 Miss latency: pal_valid asserted the cycle after mem_rd_valid.
REQ-014 If offset >= TILE_COLS*TILE_ROWS, SHALL go IDLE -> OUT directly, pal_err=1, pal_sel=0, no mem_req; pal_valid the cycle after accept.
REQ-015 mem_rd_valid outside WAIT SHALL be ignored.
REQ-016 mem_gnt and mem_rd_valid in the same ISSUE cycle: SHALL treat as grant only; data is expected in a later cycle.

Reset
REQ-017 On rst_n low, SHALL immediately enter IDLE; mem_req=0, pal_valid=0, pal_sel=0, pal_err=0, mem_addr=0, cache invalid.
REQ-018 Reset mid-transaction SHALL abandon it; late mem_rd_valid is ignored per REQ-015.

Configuration
REQ-019 Macro ATTR_FETCH_CACHE_EN SHALL compile in a one-entry cache (tag = mem_addr, 8-bit data, valid bit).
REQ-020 With ATTR_FETCH_CACHE_EN: hit on accept SHALL go IDLE -> OUT, pal_valid the next cycle, no mem_req; each miss fill updates the entry; cache_inval or reset clears valid; cache_inval on the fill cycle wins (entry stays invalid, result still delivered).
REQ-021 Without ATTR_FETCH_CACHE_EN: every non-error request SHALL issue mem_req; cache_inval ignored.

Structure
REQ-022 Package ppu_bg_pkg SHALL hold the state enum, mirror-mode codes and NT_BASE/attribute-offset default constants.
REQ-023 Address/shift decode SHALL be the combinational sub-module attr_addr_calc (req_addr, mirror_mode -> mem_addr, shift, err).

Verification
REQ-024 Vertical mode, req 0x20A6, memory returns 0xE4 -> mem_addr 0x23C9, pal_sel 1, pal_err 0.
REQ-025 Horizontal mode, req 0x2C42, data 0xE4 -> mem_addr 0x27C0, pal_sel 3.
REQ-026 req 0x23C5 -> no mem_req, pal_valid next cycle, pal_err 1, pal_sel 0.
REQ-027 With cache: after REQ-024, req 0x20A7 -> no mem_req, pal_valid one cycle after accept, pal_sel 1; after cache_inval pulse, same req issues mem_req.
REQ-028 mem_gnt delayed 5 cycles, pal_ready low 3 cycles -> mem_addr and pal_sel stable throughout, req_ready low until pal_ready.
REQ-029 rst_n low during WAIT, then mem_rd_valid -> all outputs reset, pal_valid stays 0.

Source files
------------

// File: rtl/ppu_bg_pkg.sv
// ppu_bg_pkg: shared types and constants for the background attribute fetch path.
// Holds the fetch FSM state encoding, mirroring-mode codes, default nametable
// geometry and the attribute-byte quadrant selector.
package ppu_bg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam logic [1:0] MIRROR_HORZ  = 2'b00;
  localparam logic [1:0] MIRROR_VERT  = 2'b01;
  localparam logic [1:0] MIRROR_SGL_A = 2'b10;
  localparam logic [1:0] MIRROR_SGL_B = 2'b11;

  localparam logic [13:0] NT_BASE_DEF  = 14'h2000;
  localparam logic [13:0] NT_SIZE_DEF  = 14'h0400;
  localparam logic [13:0] ATTR_OFS_DEF = 14'h03C0;

  // Pick the 2-bit palette field of an attribute byte; shift is always even.
  function automatic logic [1:0] attr_pick(input logic [7:0] attr, input logic [2:0] shift);
    logic [1:0] sel;
    case (shift)
      3'd0:    sel = attr[1:0];
      3'd2:    sel = attr[3:2];
      3'd4:    sel = attr[5:4];
      3'd6:    sel = attr[7:6];
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/attr_addr_calc.sv
// attr_addr_calc: combinational decode of a nametable address into the
// attribute byte address, the quadrant shift within that byte, and an error
// flag when the request itself points into the attribute area.
module attr_addr_calc
  import ppu_bg_pkg::*;
#(
  parameter logic [13:0] NT_BASE   = NT_BASE_DEF,
  parameter logic [13:0] NT_SIZE   = NT_SIZE_DEF,
  parameter int          TILE_COLS = 32,
  parameter int          TILE_ROWS = 30
) (
  input  logic [13:0] req_addr,
  input  logic [1:0]  mirror_mode,
  output logic [13:0] mem_addr,
  output logic [2:0]  shift,
  output logic        err
);

  localparam int ATTR_OFS = TILE_COLS * TILE_ROWS;

  logic [1:0] logical_s;
  logic [9:0] offset_s;
  logic [9:0] row_s;
  logic [9:0] col_s;
  logic       phys_s;
  logic [1:0] addr_hi_unused_s;

  assign addr_hi_unused_s = req_addr[13:12];
  assign logical_s        = req_addr[11:10];
  assign offset_s         = req_addr[9:0];
  assign row_s            = offset_s / 10'(TILE_COLS);
  assign col_s            = offset_s % 10'(TILE_COLS);

  // Fold the logical nametable onto one of the two physical tables.
  always_comb begin
    phys_s = 1'b0;
    case (mirror_mode)
      MIRROR_HORZ:  phys_s = logical_s[1];
      MIRROR_VERT:  phys_s = logical_s[0];
      MIRROR_SGL_A: phys_s = 1'b0;
      MIRROR_SGL_B: phys_s = 1'b1;
      default:      phys_s = 1'b0;
    endcase
  end

  // One attribute byte covers a 4x4 tile block; arithmetic wraps at 14 bits.
  assign mem_addr = NT_BASE
                  + (phys_s ? NT_SIZE : 14'd0)
                  + 14'(ATTR_OFS)
                  + 14'(row_s >> 2) * 14'(TILE_COLS / 4)
                  + 14'(col_s >> 2);

  // Quadrant within the 4x4 block picks one of four 2-bit fields.
  assign shift = {row_s[1], col_s[1], 1'b0};
  assign err   = ({1'b0, offset_s} >= 11'(ATTR_OFS));

endmodule

// File: rtl/attr_fetch_ctrl.sv
// attr_fetch_ctrl: turns a nametable tile address into a 2-bit background
// palette select by fetching the matching attribute byte from PPU memory.
// Build option ATTR_FETCH_CACHE_EN adds a one-entry attribute byte cache so
// neighbouring tiles sharing an attribute byte skip the memory read.
module attr_fetch_ctrl
  import ppu_bg_pkg::*;
#(
  parameter logic [13:0] NT_BASE   = NT_BASE_DEF,
  parameter logic [13:0] NT_SIZE   = NT_SIZE_DEF,
  parameter int          TILE_COLS = 32,
  parameter int          TILE_ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [13:0] req_addr,
  input  logic [1:0]  mirror_mode,
  input  logic        cache_inval,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [13:0] mem_addr,
  input  logic        mem_rd_valid,
  input  logic [7:0]  mem_rd_data,
  output logic        pal_valid,
  input  logic        pal_ready,
  output logic [1:0]  pal_sel,
  output logic        pal_err
);

  state_e      state_q, state_d;
  logic [13:0] mem_addr_q, mem_addr_d;
  logic [2:0]  shift_q, shift_d;
  logic [1:0]  pal_sel_q, pal_sel_d;
  logic        pal_err_q, pal_err_d;
  logic        mem_req_q, mem_req_d;
  logic        pal_valid_q, pal_valid_d;

  logic [13:0] calc_addr_s;
  logic [2:0]  calc_shift_s;
  logic        calc_err_s;
  logic        hit_s;
  logic [7:0]  hit_data_s;

  attr_addr_calc #(
    .NT_BASE   (NT_BASE),
    .NT_SIZE   (NT_SIZE),
    .TILE_COLS (TILE_COLS),
    .TILE_ROWS (TILE_ROWS)
  ) u_calc (
    .req_addr    (req_addr),
    .mirror_mode (mirror_mode),
    .mem_addr    (calc_addr_s),
    .shift       (calc_shift_s),
    .err         (calc_err_s)
  );

`ifdef ATTR_FETCH_CACHE_EN
  logic        cache_valid_q, cache_valid_d;
  logic [13:0] cache_tag_q, cache_tag_d;
  logic [7:0]  cache_data_q, cache_data_d;

  // An invalidate in the same cycle as a lookup suppresses the hit.
  assign hit_s      = cache_valid_q & ~cache_inval & (cache_tag_q == calc_addr_s);
  assign hit_data_s = cache_data_q;

  // Refill on every miss return; an invalidate on the fill cycle wins.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    if ((state_q == ST_WAIT) && mem_rd_valid) begin
      cache_valid_d = ~cache_inval;
      cache_tag_d   = mem_addr_q;
      cache_data_d  = mem_rd_data;
    end else begin
      cache_valid_d = cache_valid_q & ~cache_inval;
    end
  end

  // Cache entry storage; reset leaves it invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= 14'd0;
      cache_data_q  <= 8'd0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end
`else
  logic cache_inval_unused_s;

  assign cache_inval_unused_s = cache_inval;
  assign hit_s                = 1'b0;
  assign hit_data_s           = 8'd0;
`endif

  // Fetch sequencing: accept, issue the read, wait for data, hold the result.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    shift_d    = shift_q;
    pal_sel_d  = pal_sel_q;
    pal_err_d  = pal_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          shift_d = calc_shift_s;
          if (calc_err_s) begin
            state_d   = ST_OUT;
            pal_err_d = 1'b1;
            pal_sel_d = 2'b00;
          end else if (hit_s) begin
            state_d   = ST_OUT;
            pal_err_d = 1'b0;
            pal_sel_d = attr_pick(hit_data_s, calc_shift_s);
          end else begin
            state_d    = ST_ISSUE;
            pal_err_d  = 1'b0;
            mem_addr_d = calc_addr_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A data strobe alongside the grant is not the answer to this read.
        if (mem_gnt) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_rd_valid) begin
          state_d   = ST_OUT;
          pal_sel_d = attr_pick(mem_rd_data, shift_q);
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (pal_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_req_d   = (state_d == ST_ISSUE);
  assign pal_valid_d = (state_d == ST_OUT);

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= 14'd0;
      shift_q     <= 3'd0;
      pal_sel_q   <= 2'd0;
      pal_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      pal_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      shift_q     <= shift_d;
      pal_sel_q   <= pal_sel_d;
      pal_err_q   <= pal_err_d;
      mem_req_q   <= mem_req_d;
      pal_valid_q <= pal_valid_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign pal_valid = pal_valid_q;
  assign pal_sel   = pal_sel_q;
  assign pal_err   = pal_err_q;

endmodule

// File: tb/tb_attr_fetch_ctrl.sv
// tb_attr_fetch_ctrl: randomized self-checking bench for attr_fetch_ctrl.
// The reference computes attribute addresses with plain integer arithmetic
// over a behavioural memory array; define ATTR_FETCH_CACHE_EN to model the
// one-entry cache as well.
module tb_attr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_addr;
  logic [1:0]  mirror_mode;
  logic        cache_inval;
  logic        mem_req;
  logic        mem_gnt;
  logic [13:0] mem_addr;
  logic        mem_rd_valid;
  logic [7:0]  mem_rd_data;
  logic        pal_valid;
  logic        pal_ready;
  logic [1:0]  pal_sel;
  logic        pal_err;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [7:0]  mem [0:16383];
  bit          c_valid = 1'b0;
  int          c_tag   = 0;

  always #5 clk = ~clk;

  attr_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .mirror_mode  (mirror_mode),
    .cache_inval  (cache_inval),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_addr     (mem_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .pal_valid    (pal_valid),
    .pal_ready    (pal_ready),
    .pal_sel      (pal_sel),
    .pal_err      (pal_err)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decode from the nametable geometry (32x30 tiles, 1 KiB tables).
  function automatic void ref_lookup(input int a, input int m, output int addr,
                                     output bit err, output int shift);
    int lt, off, row, col, phys;
    lt  = (a / 1024) % 4;
    off = a % 1024;
    row = off / 32;
    col = off % 32;
    case (m)
      0:       phys = lt / 2;
      1:       phys = lt % 2;
      2:       phys = 0;
      default: phys = 1;
    endcase
    addr  = (8192 + phys * 1024 + 960 + (row / 4) * 8 + col / 4) % 16384;
    err   = (off >= 960);
    shift = 4 * ((row / 2) % 2) + 2 * ((col / 2) % 2);
  endfunction

  task automatic idle_inval();
    cache_inval = 1'b1;
    @(negedge clk);
    cache_inval = 1'b0;
    c_valid = 1'b0;
  endtask

  // One full lookup with configurable grant/data/consumer delays.
  task automatic txn(input logic [13:0] a, input logic [1:0] m, input int gnt_dly,
                     input int rd_dly, input int rdy_dly, input bit dual, input bit inval_fill);
    int         exp_addr, shift, exp_sel;
    bit         err, hit;
    logic [7:0] d;
    ref_lookup(int'(a), int'(m), exp_addr, err, shift);
    hit = 1'b0;
`ifdef ATTR_FETCH_CACHE_EN
    hit = c_valid && (c_tag == exp_addr) && !err;
`endif
    d       = mem[exp_addr];
    exp_sel = err ? 0 : ((int'(d) >> shift) & 3);

    check_eq("req_ready_idle", 16'(req_ready), 16'd1);
    req_valid   = 1'b1;
    req_addr    = a;
    mirror_mode = m;
    @(negedge clk);
    req_valid   = 1'b0;
    req_addr    = 14'($urandom);
    mirror_mode = 2'($urandom);
    check_eq("req_ready_busy", 16'(req_ready), 16'd0);

    if (err || hit) begin
      check_eq("mem_req_none", 16'(mem_req), 16'd0);
      check_eq("pal_valid_fast", 16'(pal_valid), 16'd1);
    end else begin
      check_eq("pal_valid_early", 16'(pal_valid), 16'd0);
      for (int i = 0; i <= gnt_dly; i++) begin
        check_eq("mem_req_hold", 16'(mem_req), 16'd1);
        check_eq("mem_addr", 16'(mem_addr), 16'(exp_addr));
        if (i == gnt_dly) begin
          mem_gnt = 1'b1;
          if (dual) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = ~d;
          end
        end
        @(negedge clk);
        mem_gnt      = 1'b0;
        mem_rd_valid = 1'b0;
      end
      check_eq("mem_req_drop", 16'(mem_req), 16'd0);
      for (int i = 0; i < rd_dly; i++) begin
        check_eq("pal_valid_wait", 16'(pal_valid), 16'd0);
        @(negedge clk);
      end
      mem_rd_valid = 1'b1;
      mem_rd_data  = d;
      cache_inval  = inval_fill;
      @(negedge clk);
      mem_rd_valid = 1'b0;
      cache_inval  = 1'b0;
      mem_rd_data  = 8'($urandom);
      c_valid      = !inval_fill;
      c_tag        = exp_addr;
    end

    for (int i = 0; i <= rdy_dly; i++) begin
      check_eq("pal_valid_hold", 16'(pal_valid), 16'd1);
      check_eq("pal_sel", 16'(pal_sel), 16'(exp_sel));
      check_eq("pal_err", 16'(pal_err), 16'(err));
      check_eq("req_ready_out", 16'(req_ready), 16'd0);
      check_eq("mem_req_out", 16'(mem_req), 16'd0);
      if (i == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'($urandom);
      end
      if (i == rdy_dly) pal_ready = 1'b1;
      @(negedge clk);
      pal_ready    = 1'b0;
      mem_rd_valid = 1'b0;
    end
    check_eq("pal_valid_done", 16'(pal_valid), 16'd0);
    check_eq("req_ready_done", 16'(req_ready), 16'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 16'(req_ready), 16'd1);
    check_eq({tag, "_mem_req"}, 16'(mem_req), 16'd0);
    check_eq({tag, "_mem_addr"}, 16'(mem_addr), 16'd0);
    check_eq({tag, "_pal_valid"}, 16'(pal_valid), 16'd0);
    check_eq({tag, "_pal_sel"}, 16'(pal_sel), 16'd0);
    check_eq({tag, "_pal_err"}, 16'(pal_err), 16'd0);
  endtask

  initial begin
    logic [13:0] pool [0:3];
    logic [13:0] a;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 14'd0;
    mirror_mode  = 2'd0;
    cache_inval  = 1'b0;
    mem_gnt      = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = 8'd0;
    pal_ready    = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[14'h23C9] = 8'hE4;
    mem[14'h27C0] = 8'hE4;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Worked examples: vertical/horizontal lookups, attribute-area error.
    txn(14'h20A6, 2'b01, 0, 0, 0, 1'b0, 1'b0);
    txn(14'h20A7, 2'b01, 0, 1, 0, 1'b0, 1'b0);
    idle_inval();
    txn(14'h20A7, 2'b01, 1, 0, 0, 1'b0, 1'b0);
    txn(14'h2C42, 2'b00, 0, 0, 1, 1'b1, 1'b0);
    txn(14'h23C5, 2'b01, 0, 0, 0, 1'b0, 1'b0);
    idle_inval();
    txn(14'h2C42, 2'b00, 5, 2, 3, 1'b0, 1'b0);

    // Reset while waiting for data; the late strobe must be ignored.
    idle_inval();
    req_valid   = 1'b1;
    req_addr    = 14'h20A6;
    mirror_mode = 2'b01;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rstw_mem_req", 16'(mem_req), 16'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check_eq("rstw_wait", 16'(mem_req), 16'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstw_async");
    c_valid = 1'b0;
    @(negedge clk);
    rst_n        = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 8'hE4;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    check_reset_outputs("rstw_late");
    @(negedge clk);
    check_reset_outputs("rstw_late2");

    // Randomized traffic over all mirroring modes, with address reuse for hits.
    for (int i = 0; i < 4; i++) pool[i] = 14'h2000 + 14'($urandom_range(0, 14'h1EFF));
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) == 0) a = pool[$urandom_range(0, 3)] ^ 14'($urandom_range(0, 1));
      else a = 14'h2000 + 14'($urandom_range(0, 14'h1EFF));
      if ($urandom_range(0, 9) == 0) idle_inval();
      txn(a, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
